serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word width in bits (legal 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first received bit lands in dout[WIDTH-1] and 0 = first bit lands in dout[0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sin  input  1  serial data bit, sampled only when sin_valid=1.
REQ-006 SHALL have port sin_valid  input  1  serial bit strobe, at most one bit per cycle.
REQ-007 SHALL have port sync  input  1  frame restart: discards any partial word.
REQ-008 SHALL have port dout  output  WIDTH  completed parallel word.
REQ-009 SHALL have port dout_valid  output  1  holding register contains an unconsumed word.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1 in the same cycle.
REQ-011 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 SHALL have port clr_ovr  input  1  synchronous clear of overrun.
REQ-013 SHALL have port parity_err  output  1  parity result for the word in dout; see Configuration.

Function
REQ-014 SHALL hold a shift register and a bit counter of $clog2(FRAME+1) bits, where FRAME = WIDTH, or WIDTH+1 with parity.
REQ-015 SHALL, when sin_valid=1, shift sin into the shift register according to MSB_FIRST and increment the counter.
REQ-016 SHALL complete a frame when the counter equals FRAME-1 and sin_valid=1; the counter then wraps to 0 in that same edge.
REQ-017 SHALL load the completed word into dout and assert dout_valid on the edge that accepts the final bit, so dout_valid is visible the cycle after that bit: latency 1.
REQ-018 SHALL clear dout_valid after a handshake (dout_valid=1 and dout_ready=1) unless a new word completes in the same cycle.
REQ-019 SHALL, on a same-cycle handshake and frame completion, load the new word and keep dout_valid=1 without a bubble and without setting overrun.
REQ-020 SHALL, on frame completion while dout_valid=1 and dout_ready=0, drop the new word, leave dout unchanged and set overrun.
REQ-021 SHALL hold dout stable while dout_valid=1 and dout_ready=0.
REQ-022 SHALL, when sync=1 and sin_valid=0, set the counter to 0 and discard the partial word.
REQ-023 SHALL, when sync=1 and sin_valid=1, discard the partial word and take sin as bit 0 of the new frame (counter becomes 1).
REQ-024 SHALL never let sync complete a frame.
REQ-025 SHALL not let sync affect dout, dout_valid or overrun.
REQ-026 SHALL keep overrun at 1 until clr_ovr=1 or rst.
REQ-027 SHALL, when clr_ovr=1 coincides with a new overrun event, leave overrun at 1 (set wins).

Reset
REQ-028 SHALL, while rst=1, asynchronously force the counter, shift register and dout to 0.
REQ-029 SHALL, while rst=1, asynchronously force dout_valid, overrun and parity_err to 0.
REQ-030 SHALL, when rst asserts mid-frame, discard the partial word; the first sin_valid after rst deasserts is bit 0 of a new frame.

Configuration
REQ-031 SHALL, with macro DESER_PARITY_EN defined, use FRAME = WIDTH+1, where the last bit is an even-parity bit over the WIDTH data bits and is not stored in dout.
REQ-032 SHALL, with DESER_PARITY_EN defined, load parity_err with the parity mismatch (1 = odd total ones) together with dout, following the same drop and hold rules as dout.
REQ-033 SHALL, without DESER_PARITY_EN, use FRAME = WIDTH and drive parity_err constantly 0.

Verification
REQ-034 SHALL cover: WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, dout_ready=1 -> dout=8'hA5 with dout_valid high for exactly one cycle after the 8th bit.
REQ-035 SHALL cover: MSB_FIRST=0, same bit stream -> dout=8'hA5 bit-reversed, 8'hA5 becoming 8'hA5 read LSB-first, i.e. dout=8'hA5 reversed = 8'hA5 (palindrome check), then stream 1,1,0,0,0,0,0,0 -> dout=8'h03.
REQ-036 SHALL cover: dout_ready=0, send two full words 8'h11 then 8'h22 -> dout stays 8'h11, overrun=1; then clr_ovr=1 -> overrun=0.
REQ-037 SHALL cover: 3 bits sent, then sync=1 with sin_valid=1, sin=1, then 7 more bits 0 -> with MSB_FIRST=1, dout=8'h80 and no earlier word emitted.
REQ-038 SHALL cover: rst pulsed asynchronously (between clock edges) after 5 bits -> all outputs 0 immediately; the next 8 bits form a correct word.
REQ-039 SHALL cover: with DESER_PARITY_EN, data 8'h07 plus parity bit 1 -> parity_err=0; data 8'h07 plus parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with a one-word holding register, sticky overrun and sync restart.
// Define DESER_PARITY_EN to append an even-parity bit to each frame and report mismatches on parity_err.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             parity_err
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0] sh_q, sh_d, sh_base, shifted, word_c;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             complete, data_bit, load, drop;

`ifdef DESER_PARITY_EN
  logic par_q, par_d, par_base;
  logic perr_q, perr_d;
`endif

  always_comb begin
    // sync clears the partial frame first, so a same-cycle bit becomes bit 0 of the next frame
    cnt_base = sync ? '0 : cnt_q;
    sh_base  = sync ? '0 : sh_q;
`ifdef DESER_PARITY_EN
    par_base = sync ? 1'b0 : par_q;
    data_bit = (cnt_base < CW'(WIDTH));
`else
    data_bit = 1'b1;
`endif
    shifted  = MSB_FIRST ? {sh_base[WIDTH-2:0], sin} : {sin, sh_base[WIDTH-1:1]};
    word_c   = data_bit ? shifted : sh_q;
    complete = sin_valid && !sync && (cnt_q == CW'(FRAME - 1));
    load     = complete && (!valid_q || dout_ready);
    drop     = complete && valid_q && !dout_ready;

    cnt_d = cnt_base;
    sh_d  = sh_base;
`ifdef DESER_PARITY_EN
    par_d  = par_base;
    perr_d = perr_q;
`endif
    if (sin_valid) begin
      if (complete) begin
        cnt_d = '0;
        sh_d  = '0;
`ifdef DESER_PARITY_EN
        par_d = 1'b0;
`endif
      end else begin
        cnt_d = cnt_base + CW'(1);
        if (data_bit) begin
          sh_d = shifted;
`ifdef DESER_PARITY_EN
          par_d = par_base ^ sin;
`endif
        end
      end
    end

    dout_d  = dout_q;
    valid_d = valid_q;
    if (load) begin
      dout_d  = word_c;
      valid_d = 1'b1;
`ifdef DESER_PARITY_EN
      perr_d = par_q ^ sin;
`endif
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end

    if (drop)         ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: MSB-first and LSB-first instances driven in parallel,
// directed scenarios followed by random traffic, all checked against a bit-queue model.
module tb_serial_deserializer;

`ifdef DESER_PARITY_EN
  localparam int FRAME = 9;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = 8;
  localparam bit PAR   = 1'b0;
`endif

  logic clk, rst, sin, sin_valid, sync, dout_ready, clr_ovr;
  logic [7:0] m_dout, l_dout;
  logic m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr;

  int errors = 0;
  int checks = 0;

  bit       q[$];
  logic [7:0] e_msb, e_lsb;
  logic       e_valid, e_ovr, e_perr;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .dout(m_dout), .dout_valid(m_valid), .dout_ready(dout_ready),
    .overrun(m_ovr), .clr_ovr(clr_ovr), .parity_err(m_perr)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .dout(l_dout), .dout_valid(l_valid), .dout_ready(dout_ready),
    .overrun(l_ovr), .clr_ovr(clr_ovr), .parity_err(l_perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".msb.dout"},  m_dout,  e_msb);
    chk({tag, ".msb.valid"}, m_valid, e_valid);
    chk({tag, ".msb.ovr"},   m_ovr,   e_ovr);
    chk({tag, ".msb.perr"},  m_perr,  e_perr);
    chk({tag, ".lsb.dout"},  l_dout,  e_lsb);
    chk({tag, ".lsb.valid"}, l_valid, e_valid);
    chk({tag, ".lsb.ovr"},   l_ovr,   e_ovr);
    chk({tag, ".lsb.perr"},  l_perr,  e_perr);
  endtask

  task automatic model_reset();
    q.delete();
    e_msb = '0; e_lsb = '0; e_valid = 1'b0; e_ovr = 1'b0; e_perr = 1'b0;
  endtask

  // Frame = list of received bits; a full list is converted with plain arithmetic.
  task automatic model_step();
    bit done, ovr_set;
    int w_msb, w_lsb, ones;
    done = 0; ovr_set = 0;
    w_msb = 0; w_lsb = 0; ones = 0;
    if (sync) q.delete();
    if (sin_valid) begin
      q.push_back(sin);
      if (q.size() == FRAME) begin
        done = 1;
        for (int i = 0; i < 8; i++) begin
          w_msb = w_msb * 2 + int'(q[i]);
          w_lsb = w_lsb + (int'(q[i]) << i);
        end
        for (int i = 0; i < FRAME; i++) ones += int'(q[i]);
        q.delete();
      end
    end
    if (done) begin
      if (!e_valid || dout_ready) begin
        e_msb   = 8'(w_msb);
        e_lsb   = 8'(w_lsb);
        e_perr  = PAR ? ((ones % 2) == 1) : 1'b0;
        e_valid = 1'b1;
      end else begin
        ovr_set = 1;
      end
    end else if (e_valid && dout_ready) begin
      e_valid = 1'b0;
    end
    if (ovr_set)      e_ovr = 1'b1;
    else if (clr_ovr) e_ovr = 1'b0;
  endtask

  task automatic step(input logic b_sv, input logic b_sin, input logic b_sync,
                      input logic b_rdy, input logic b_clr);
    sin_valid = b_sv; sin = b_sin; sync = b_sync; dout_ready = b_rdy; clr_ovr = b_clr;
    model_step();
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) step(1'b1, val[i], 1'b0, rdy, 1'b0);
  endtask

  // Sends d first-bit-first from d[7], plus the even parity bit when enabled.
  task automatic send_frame(input logic [7:0] d, input logic rdy, input logic rdy_last);
    logic [FRAME-1:0] fb;
`ifdef DESER_PARITY_EN
    fb = {d, ^d};
`else
    fb = d;
`endif
    for (int i = FRAME - 1; i >= 0; i--) step(1'b1, fb[i], 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sin = 0; sin_valid = 0; sync = 0; dout_ready = 0; clr_ovr = 0;
    model_reset();
    #2;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held");
    rst = 1'b0;

    // 1,0,1,0,0,1,0,1 -> A5 for both orders (palindrome), valid for one cycle
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("a5.msb", m_dout, 8'hA5);
    chk("a5.lsb", l_dout, 8'hA5);
    chk("a5.valid", m_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5.valid_drop", m_valid, 1'b0);

    // 1,1,0,0,0,0,0,0 -> LSB-first 03, MSB-first C0
    send_frame(8'hC0, 1'b1, 1'b1);
    chk("c0.lsb", l_dout, 8'h03);
    chk("c0.msb", m_dout, 8'hC0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // overrun: second word dropped while the first is held
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    chk("ovr.msb_hold", m_dout, 8'h11);
    chk("ovr.lsb_hold", l_dout, 8'h88);
    chk("ovr.flag", m_ovr, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr.sticky", m_ovr, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr.clear", m_ovr, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // handshake coinciding with completion: no bubble, no overrun
    send_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    chk("b2b.dout", m_dout, 8'h3C);
    chk("b2b.valid", m_valid, 1'b1);
    chk("b2b.ovr", m_ovr, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // sync with a bit restarts the frame on that bit
    send_bits(32'b101, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_bits(32'h0, 7, 1'b1);
`ifdef DESER_PARITY_EN
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    chk("sync.msb", m_dout, 8'h80);
    chk("sync.lsb", l_dout, 8'h01);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // asynchronous reset mid-frame
    send_bits(32'b10110, 5, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst.dout", m_dout, 8'h00);
    chk("arst.valid", m_valid, 1'b0);
    chk("arst.ovr", m_ovr, 1'b0);
    chk("arst.perr", m_perr, 1'b0);
    rst = 1'b0;
    model_reset();
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("arst.word", m_dout, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DESER_PARITY_EN
    send_bits({23'd0, 8'h07, 1'b1}, 9, 1'b1);
    chk("par.ok", m_perr, 1'b0);
    send_bits({23'd0, 8'h07, 1'b0}, 9, 1'b1);
    chk("par.bad", m_perr, 1'b1);
`else
    send_bits({24'd0, 8'h07}, 8, 1'b1);
    chk("par.off", m_perr, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(99) < 75), 1'($urandom), ($urandom_range(99) < 4),
           ($urandom_range(99) < 50), ($urandom_range(99) < 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
